// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter and the blocks around it.
// to_bin models the downstream gray-to-binary decoder so benches can reuse it.
package gray_pkg;

    localparam int GRAY_W = 4;

    // Binary to reflected Gray: each Gray bit is the XOR of two adjacent binary bits.
    function automatic logic [GRAY_W-1:0] to_gray(input logic [GRAY_W-1:0] bin_val);
        return bin_val ^ (bin_val >> 1);
    endfunction

    // Gray to binary: prefix XOR running from the MSB down.
    function automatic logic [GRAY_W-1:0] to_bin(input logic [GRAY_W-1:0] gray_val);
        logic [GRAY_W-1:0] bin_val;
        bin_val[GRAY_W-1] = gray_val[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin_val[i] = bin_val[i+1] ^ gray_val[i];
        end
        return bin_val;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and result bundle of the Gray counter.
// master drives the count controls; slave is the counter itself.
interface gray_counter_if
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) ();

    logic             en;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] bin;
    logic             tc;

    modport master (
        output en, up, ld, ld_val,
        input  op, bin, tc
    );

    modport slave (
        input  en, up, ld, ld_val,
        output op, bin, tc
    );

endinterface

// File: rtl/bin2gray.sv
// Purely combinational binary to Gray converter of arbitrary width.
// Sits on the next-count path so the Gray register loads on the same edge as the binary one.
module bin2gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray_out
);

    assign gray_out = bin_in ^ (bin_in >> 1);

endmodule

// File: rtl/gray_counter.sv
// Synchronous up/down Gray-code counter with parallel binary load.
// Keeps a binary count internally; the Gray word is registered alongside it.
// WRAP selects modulo wrap-around (tc after the wrapping edge) or saturation
// (tc on every enabled edge that is stalled at a limit).
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter bit WRAP  = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    gray_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             tc_q, tc_d;

    // Next binary count and terminal-count flag; limits are detected by compare, not carry.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (bus.ld) begin
            cnt_d = bus.ld_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (cnt_q == ALL_ONES) begin
                    cnt_d = WRAP ? ZERO : ALL_ONES;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == ZERO) begin
                    cnt_d = WRAP ? ALL_ONES : ZERO;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin_in   (cnt_d),
        .gray_out (op_d)
    );

    // Binary count, Gray word and tc all register on the same edge; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.op  = op_q;
    assign bus.bin = cnt_q;
    assign bus.tc  = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: one wrapping and one saturating instance
// driven with identical stimulus, checked against fixed vectors and a reference model.
module tb_gray_counter;
    import gray_pkg::*;

    logic clk;
    logic rst;

    gray_counter_if #(.WIDTH(4)) wrap_if ();
    gray_counter_if #(.WIDTH(4)) sat_if ();

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wrap_if)
    );

    gray_counter #(.WIDTH(4), .WRAP(1'b0)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sat_if)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors;
    int n_miscompares;

    // Reference model state: index 0 = wrapping counter, index 1 = saturating counter.
    int m_cnt [2];
    int m_tc  [2];

    // Gray sequence built by reflection, independent of any XOR formula.
    int gtab [16];

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [3:0] ld_val;
        logic [3:0] exp_op;
        logic [3:0] exp_bin;
        logic       exp_tc;
    } vec_t;

    vec_t vecs [11];

    task automatic checkValue(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Advance the model by one edge using plain integer arithmetic.
    task automatic modelStep(input logic r, input logic e, input logic u,
                             input logic l, input logic [3:0] lv);
        for (int k = 0; k < 2; k++) begin
            int n;
            if (r) begin
                m_cnt[k] = 0;
                m_tc[k]  = 0;
            end else if (l) begin
                m_cnt[k] = int'(lv);
                m_tc[k]  = 0;
            end else if (e) begin
                n = m_cnt[k] + (u ? 1 : -1);
                if (n < 0 || n > 15) begin
                    m_cnt[k] = (k == 0) ? (n + 16) % 16 : m_cnt[k];
                    m_tc[k]  = 1;
                end else begin
                    m_cnt[k] = n;
                    m_tc[k]  = 0;
                end
            end else begin
                m_tc[k] = 0;
            end
        end
    endtask

    // Drive inputs away from the active edge, step the model, sample 1 unit after the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lv);
        @(negedge clk);
        rst            = r;
        wrap_if.en     = e;
        wrap_if.up     = u;
        wrap_if.ld     = l;
        wrap_if.ld_val = lv;
        sat_if.en      = e;
        sat_if.up      = u;
        sat_if.ld      = l;
        sat_if.ld_val  = lv;
        modelStep(r, e, u, l, lv);
        @(posedge clk);
        #1;
    endtask

    // Compare both instances with the model and with the downstream decoder.
    task automatic checkOutput(input string tag);
        checkValue({tag, " wrap.bin"}, int'(wrap_if.bin), m_cnt[0]);
        checkValue({tag, " wrap.op"},  int'(wrap_if.op),  gtab[m_cnt[0]]);
        checkValue({tag, " wrap.tc"},  int'(wrap_if.tc),  m_tc[0]);
        checkValue({tag, " wrap.dec"}, int'(to_bin(wrap_if.op)), int'(wrap_if.bin));
        checkValue({tag, " sat.bin"},  int'(sat_if.bin),  m_cnt[1]);
        checkValue({tag, " sat.op"},   int'(sat_if.op),   gtab[m_cnt[1]]);
        checkValue({tag, " sat.tc"},   int'(sat_if.tc),   m_tc[1]);
        checkValue({tag, " sat.dec"},  int'(to_bin(sat_if.op)), int'(sat_if.bin));
    endtask

    initial begin
        int len;
        logic [3:0] prev_op;
        logic r, e, u, l;
        logic [3:0] lv;

        n_vectors     = 0;
        n_miscompares = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_tc[0]  = 0; m_tc[1]  = 0;

        gtab[0] = 0;
        gtab[1] = 1;
        len = 2;
        for (int b = 1; b < 4; b++) begin
            for (int i = 0; i < len; i++) begin
                gtab[len + i] = gtab[len - 1 - i] | (1 << b);
            end
            len = len * 2;
        end

        rst = 1'b1;
        wrap_if.en = 1'b0; wrap_if.up = 1'b0; wrap_if.ld = 1'b0; wrap_if.ld_val = 4'h0;
        sat_if.en  = 1'b0; sat_if.up  = 1'b0; sat_if.ld  = 1'b0; sat_if.ld_val  = 4'h0;

        // Fixed vectors; expectations are for the wrapping instance.
        vecs[0]  = '{"reset_wins",      1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'b0000, 4'h0, 1'b0};
        vecs[1]  = '{"first_up",        1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0001, 4'h1, 1'b0};
        vecs[2]  = '{"load_priority",   1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 4'b0101, 4'h6, 1'b0};
        vecs[3]  = '{"after_load_up",   1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0100, 4'h7, 1'b0};
        vecs[4]  = '{"load_zero",       1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0000, 4'h0, 1'b0};
        vecs[5]  = '{"down_wrap",       1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1000, 4'hF, 1'b1};
        vecs[6]  = '{"down_after_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b1001, 4'hE, 1'b0};
        vecs[7]  = '{"hold",            1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 4'b1001, 4'hE, 1'b0};
        vecs[8]  = '{"dir_change_up",   1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b1000, 4'hF, 1'b0};
        vecs[9]  = '{"up_wrap",         1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 4'h0, 1'b1};
        vecs[10] = '{"reset_mid_count", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 4'h0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].ld_val);
            checkValue({vecs[i].name, " op"},  int'(wrap_if.op),  int'(vecs[i].exp_op));
            checkValue({vecs[i].name, " bin"}, int'(wrap_if.bin), int'(vecs[i].exp_bin));
            checkValue({vecs[i].name, " tc"},  int'(wrap_if.tc),  int'(vecs[i].exp_tc));
            checkOutput(vecs[i].name);
        end

        // Full up sweep from zero on the wrapping instance.
        prev_op = wrap_if.op;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
            checkValue("sweep op",  int'(wrap_if.op), gtab[(i + 1) % 16]);
            checkValue("sweep tc",  int'(wrap_if.tc), (i == 15) ? 1 : 0);
            checkValue("sweep one_bit", $countones(wrap_if.op ^ prev_op), 1);
            prev_op = wrap_if.op;
        end

        // Saturation at the top: load E then count up three times.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hE);
        checkOutput("sat_load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
            checkValue("sat_top bin", int'(sat_if.bin), 15);
            checkValue("sat_top op",  int'(sat_if.op),  8);
            checkValue("sat_top tc",  int'(sat_if.tc),  (i == 0) ? 0 : 1);
        end

        // Saturation at the bottom: load 1 then count down twice.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkValue("sat_bot bin", int'(sat_if.bin), 0);
        checkValue("sat_bot tc",  int'(sat_if.tc),  0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkValue("sat_bot hold bin", int'(sat_if.bin), 0);
        checkValue("sat_bot hold tc",  int'(sat_if.tc),  1);

        // Randomized run against the model, with the single-bit-change rule on counting steps.
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            lv = 4'($urandom_range(0, 15));
            prev_op = wrap_if.op;
            applyStimulus(r, e, u, l, lv);
            checkOutput("random");
            if (!r && !l && e) begin
                checkValue("random one_bit", $countones(wrap_if.op ^ prev_op), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
